// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier host interface:
// register offsets, APB slave FSM encoding and bus-word element count.
package matmul_pkg;

    localparam logic [4:0] REG_CONTROL   = 5'h00;
    localparam logic [4:0] REG_OPERAND_A = 5'h04;
    localparam logic [4:0] REG_FLAGS     = 5'h08;
    localparam logic [4:0] REG_OPERAND_B = 5'h0C;
    localparam logic [4:0] REG_SP        = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Elements carried by one bus word; also the width of the write strobe.
    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational legality check of a register access.
// With BUSY_LOCK_EN defined, writes to writable registers are refused while busy.
module apb_addr_decode
    import matmul_pkg::*;
(
    input  logic [4:0] offset,
    input  logic       write,
    input  logic       busy,
    output logic       error
);

    logic known;
    logic read_only;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        known     = 1'b0;
        read_only = 1'b0;
        case (offset)
            REG_CONTROL, REG_OPERAND_A, REG_OPERAND_B: known = 1'b1;
            REG_FLAGS, REG_SP: begin
                known     = 1'b1;
                read_only = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

`ifdef BUSY_LOCK_EN
    assign error = !known || (write && (read_only || busy));
`else
    logic busy_unused;
    assign busy_unused = busy;
    assign error       = !known || (write && read_only);
`endif

endmodule

// File: rtl/apb_slave_module.sv
// APB slave in front of the matmul register file: one fixed wait state,
// single-cycle write strobe, registered read data. Optional macro: BUSY_LOCK_EN.
module apb_slave_module
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BUS_WIDTH  = 64,
    parameter  int ADDR_WIDTH = 32,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [BUS_WIDTH-1:0]  pwdata_i,
    input  logic [MAX_DIM-1:0]    pstrb_i,
    output logic [BUS_WIDTH-1:0]  prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [BUS_WIDTH-1:0]  data_o,
    output logic [MAX_DIM-1:0]    strobe_o,
    output logic                  write_enable_o,
    input  logic [BUS_WIDTH-1:0]  rdata_i,
    input  logic                  busy_i
);

    apb_state_e state;
    apb_state_e state_next;
    logic       capture;
    logic       write_q;
    logic       err_q;
    logic       decode_err;

    // The transfer is latched at SETUP entry, so decode can run on registered
    // values and the strobe can be registered to land exactly in ACCESS.
    apb_addr_decode u_decode (
        .offset (address_o[4:0]),
        .write  (write_q),
        .busy   (busy_i),
        .error  (decode_err)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_next = ST_SETUP;
                    capture    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!psel_i)
                    state_next = ST_IDLE;
                else if (penable_i)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                if (psel_i && !penable_i) begin
                    state_next = ST_SETUP;
                    capture    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            address_o      <= '0;
            data_o         <= '0;
            strobe_o       <= '0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            write_enable_o <= 1'b0;
            pready_o       <= 1'b0;
            pslverr_o      <= 1'b0;
            prdata_o       <= '0;
        end else begin
            write_enable_o <= 1'b0;
            pready_o       <= 1'b0;
            pslverr_o      <= 1'b0;
            if (capture) begin
                address_o <= paddr_i;
                data_o    <= pwdata_i;
                strobe_o  <= pstrb_i;
                write_q   <= pwrite_i;
            end
            if (state == ST_SETUP && state_next == ST_ACCESS) begin
                err_q          <= decode_err;
                write_enable_o <= write_q && !decode_err;
            end
            if (state == ST_ACCESS) begin
                pready_o  <= 1'b1;
                pslverr_o <= err_q;
                if (err_q)
                    prdata_o <= '0;
                else if (!write_q)
                    prdata_o <= rdata_i;
            end
        end
    end

endmodule
